// File: rtl/led_row_fifo_wr.sv
// Row serialiser for the LED FIFO: takes one packed row of zone bytes and writes it byte 0 first.
// Optional trailing XOR checksum byte per row when LED_ROW_CHKSUM_EN is defined.
module led_row_fifo_wr #(
  parameter int BYTE_NUM = 40,
  parameter int ROW_NUM  = 36
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic [8*BYTE_NUM-1:0] row_data,
  input  logic                  row_valid,
  output logic                  row_ready,
  input  logic                  frame_sync,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [7:0]            fifo_din,
  output logic [5:0]            row_cnt,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  dbg_state
);

  localparam int CW = $clog2(BYTE_NUM + 1);
`ifdef LED_ROW_CHKSUM_EN
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTE_NUM);
`else
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTE_NUM - 1);
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  logic [8*BYTE_NUM-1:0] shift_reg;
  logic [CW-1:0]         byte_cnt;
  logic                  sync_pend;
  logic                  wr;
  logic                  row_done;

  // Row handshake: a row transfers on any rising edge where row_valid and row_ready
  // are both high; row_ready is high only in IDLE and the source holds row_valid until then.
  assign row_ready  = (state == IDLE);
  assign busy       = (state == SEND);
  assign dbg_state  = (state == SEND);
  assign wr         = (state == SEND) && !fifo_full;
  assign fifo_wr_en = wr;
  assign row_done   = wr && (byte_cnt == LAST_BYTE);

`ifdef LED_ROW_CHKSUM_EN
  logic [7:0] chk_acc;

  assign fifo_din = (byte_cnt == CW'(BYTE_NUM)) ? chk_acc : shift_reg[7:0];

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_acc <= '0;
    end else if (state == IDLE && row_valid) begin
      chk_acc <= '0;
    end else if (wr) begin
      // The register is already zero by the checksum byte, so the extra XOR is harmless.
      chk_acc <= chk_acc ^ shift_reg[7:0];
    end
  end
`else
  assign fifo_din = shift_reg[7:0];
`endif

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      byte_cnt   <= '0;
      sync_pend  <= 1'b0;
      row_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          sync_pend <= 1'b0;
          if (frame_sync) row_cnt <= '0;
          if (row_valid) begin
            shift_reg <= row_data;
            byte_cnt  <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (frame_sync) sync_pend <= 1'b1;
          if (wr) begin
            shift_reg <= shift_reg >> 8;
            byte_cnt  <= byte_cnt + CW'(1);
          end
          if (row_done) begin
            state     <= IDLE;
            sync_pend <= 1'b0;
            // A sync seen anywhere in this row (including its last cycle) restarts the frame silently.
            if (sync_pend || frame_sync) begin
              row_cnt <= '0;
            end else if (row_cnt == 6'(ROW_NUM - 1)) begin
              row_cnt    <= '0;
              frame_done <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 6'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_row_fifo_wr.sv
// Bench for led_row_fifo_wr: row driver plus byte scoreboard against a row/frame reference model.
// Also exercises the checksum variant when LED_ROW_CHKSUM_EN is defined.
module tb_led_row_fifo_wr;

  localparam int BN = 40;
  localparam int RN = 36;
  localparam int W  = 8 * BN;
`ifdef LED_ROW_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic         wr_clk;
  logic         rst_n;
  logic [W-1:0] row_data;
  logic         row_valid;
  logic         row_ready;
  logic         frame_sync;
  logic         fifo_full;
  logic         fifo_wr_en;
  logic [7:0]   fifo_din;
  logic [5:0]   row_cnt;
  logic         frame_done;
  logic         busy;
  logic         dbg_state;

  led_row_fifo_wr #(.BYTE_NUM(BN), .ROW_NUM(RN)) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .row_data(row_data), .row_valid(row_valid),
    .row_ready(row_ready), .frame_sync(frame_sync), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .row_cnt(row_cnt),
    .frame_done(frame_done), .busy(busy), .dbg_state(dbg_state)
  );

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int frame_pulses = 0;
  int exp_frames = 0;
  int model_row = 0;

  // ---------------- clock / reset ----------------
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge wr_clk) begin
    if (rst_n) begin
      if (fifo_wr_en) begin
        check("wr_while_full", {31'd0, fifo_full}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got 0x%0h expected no write at %0t", fifo_din, $time);
        end else begin
          check("fifo_din", {24'd0, fifo_din}, {24'd0, exp_q.pop_front()});
        end
        wr_count++;
      end
      if (frame_done) begin
        frame_pulses++;
        check("frame_done_in_idle", {31'd0, row_ready}, 32'd1);
      end
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [W-1:0] incr_row();
    logic [W-1:0] r;
    for (int i = 0; i < BN; i++) r[8*i +: 8] = 8'(i + 1);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < BN; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic push_row(input logic [W-1:0] d);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < BN; i++) begin
      exp_q.push_back(d[8*i +: 8]);
      x = x ^ d[8*i +: 8];
    end
    if (CHK != 0) exp_q.push_back(x);
  endtask

  // ---------------- driver ----------------
  // sync_at: -1 none, -2 with the accept, >=0 that many SEND cycles into the row.
  task automatic send_row(input logic [W-1:0] d, input int stall_at, input int stall_len,
                          input bit rand_full, input int sync_at);
    int waitc, cycles, full_cycles, stalled;
    bit sync_seen;
    waitc = 0;
    while (!row_ready && waitc < 100) begin
      @(posedge wr_clk); #1;
      waitc++;
    end
    check("accept_wait", waitc, 0);
    if (!row_ready) return;
    row_data  = d;
    row_valid = 1'b1;
    frame_sync = (sync_at == -2);
    if (sync_at == -2) model_row = 0;
    push_row(d);
    @(posedge wr_clk); #1;
    row_valid  = 1'b0;
    frame_sync = 1'b0;
    wr_count   = 0;
    check("row_ready_low", {31'd0, row_ready}, 32'd0);
    check("row_cnt_sending", {26'd0, row_cnt}, 32'(model_row));
    cycles = 0; full_cycles = 0; stalled = 0; sync_seen = 1'b0;
    while (!row_ready && cycles < 1000) begin
      fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (wr_count == stall_at && stalled < stall_len) begin
        fifo_full = 1'b1;
        stalled++;
      end
      if (fifo_full) full_cycles++;
      frame_sync = (cycles == sync_at);
      if (frame_sync) sync_seen = 1'b1;
      @(posedge wr_clk); #1;
      cycles++;
    end
    fifo_full  = 1'b0;
    frame_sync = 1'b0;
    check("row_send_cycles", cycles, 32'(BN + CHK + full_cycles));
    check("row_write_count", wr_count, 32'(BN + CHK));
    if (sync_seen) model_row = 0;
    else if (model_row == RN - 1) begin
      model_row = 0;
      exp_frames++;
    end else model_row++;
    @(negedge wr_clk); #1;
    check("row_cnt_after", {26'd0, row_cnt}, 32'(model_row));
    check("frame_done_count", frame_pulses, exp_frames);
  endtask

  task automatic reset_mid_row(input logic [W-1:0] d, input int at_byte);
    int cycles;
    row_data  = d;
    row_valid = 1'b1;
    push_row(d);
    @(posedge wr_clk); #1;
    row_valid = 1'b0;
    wr_count  = 0;
    cycles = 0;
    while (wr_count < at_byte && cycles < 500) begin
      @(posedge wr_clk); #1;
      cycles++;
    end
    check("reset_reach_byte", wr_count, 32'(at_byte));
    rst_n = 1'b0;
    #1;
    check("rst_wr_en_drop", {31'd0, fifo_wr_en}, 32'd0);
    check("rst_row_cnt", {26'd0, row_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    model_row = 0;
    repeat (2) @(posedge wr_clk);
    #1;
    rst_n = 1'b1;
    @(posedge wr_clk); #1;
    check("rst_row_ready", {31'd0, row_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; row_data = '0; row_valid = 1'b0; frame_sync = 1'b0; fifo_full = 1'b0;
    repeat (3) @(posedge wr_clk);
    #1;
    check("reset_row_ready", {31'd0, row_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    check("reset_din", {24'd0, fifo_din}, 32'd0);
    check("reset_row_cnt", {26'd0, row_cnt}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    @(posedge wr_clk); #1;

    send_row(incr_row(), -1, 0, 1'b0, -1);
    send_row(incr_row(), 10, 3, 1'b0, -1);
    send_row({BN{8'hA5}}, -1, 0, 1'b0, -1);

    // one full frame back-to-back, wrapping through row RN-1
    for (int i = 0; i < RN; i++) send_row(rand_row(), -1, 0, 1'b0, -1);

    while (model_row != 5) send_row(rand_row(), -1, 0, 1'b0, -1);
    send_row(incr_row(), -1, 0, 1'b0, 15);

    send_row(rand_row(), -1, 0, 1'b0, -1);
    frame_sync = 1'b1;
    @(posedge wr_clk); #1;
    frame_sync = 1'b0;
    model_row = 0;
    check("idle_sync_row_cnt", {26'd0, row_cnt}, 32'd0);

    send_row(rand_row(), -1, 0, 1'b0, -1);
    send_row(rand_row(), -1, 0, 1'b0, -2);

    send_row(rand_row(), -1, 0, 1'b0, -1);
    reset_mid_row(rand_row(), 20);
    send_row(incr_row(), -1, 0, 1'b0, -1);

    for (int i = 0; i < 45; i++) begin
      int s;
      s = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BN - 1)) : -1;
      send_row(rand_row(), -1, 0, 1'b1, s);
    end

    repeat (4) @(posedge wr_clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("frame_done_total", frame_pulses, exp_frames);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
